pe_array_ctrl: RTL and testbench
================================

# pe_array_ctrl

Sequencer for the 64-channel 3×3 PE array. For each kernel it:
- reads the three weight rows from weight memory;
- drives the one-hot `ker_load` strobes that latch them into the PEs;
- streams a programmed number of activation tiles through a valid/ready handshake;
- tracks the registered multiply latency so downstream accumulation sees an aligned `mul_valid`/`mul_last`, then signals `done`.

It sits between the layer scheduler and the PE array / weight memory.

## Interface
- `ADDR_W`, 10, weight-memory address width
- `TILE_W`, 16, width of tile count
- `PE_LAT`, 1, PE multiply latency in cycles (≥1)
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin one kernel pass; sampled only in IDLE
- `wt_base`  in  ADDR_W  address of weight row 0; latched on accepted `start`
- `num_tiles`  in  TILE_W  activation tiles for this kernel; latched on accepted `start`
- `wt_rd_en`  out  1  weight-memory read strobe (memory has 1-cycle read latency)
- `wt_rd_addr`  out  ADDR_W  weight-memory read address
- `ker_load`  out  3  one-hot row strobe to PE array (bit r loads row r)
- `act_valid`  in  1  activation tile available
- `act_ready`  out  1  controller accepts a tile
- `mul_valid`  out  1  PE `multiply` output valid
- `mul_last`  out  1  qualifies the final tile's `mul_valid`
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse at end of pass
- `perf_stall`  out  TILE_W  stall-cycle count (see Configuration)

## Operation
- States:
  - IDLE: `busy`=0; `start` → LOAD, and latches `wt_base`/`num_tiles`.
  - LOAD: 4 cycles, phase counter p=0..3.
    - `wt_rd_en`=1 and `wt_rd_addr`=`wt_base`+p for p<3.
    - `ker_load`=1<<(p−1) for p≥1.
    - After p=3: go to STREAM, or to DRAIN if `num_tiles`=0.
  - STREAM: `act_ready`=1.
    - fire = `act_valid`&`act_ready` decrements the remaining-tile counter.
    - The fire that consumes the last tile → DRAIN.
  - DRAIN: PE_LAT cycles, `act_ready`=0, then DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `mul_valid` = fire delayed exactly PE_LAT cycles. `mul_last` = (fire of last tile) delayed PE_LAT cycles.
- `num_tiles`=0: weights still load; no fire, no `mul_valid`; `done` follows after DRAIN.
- Address arithmetic wraps modulo 2^ADDR_W.
- `start` outside IDLE is ignored; no queuing.
- `ker_load` is never multi-hot. `ker_load` and `act_ready` are never high in the same cycle.

## Timing
- Reset (any cycle, including mid-pass):
  - state=IDLE; valid pipeline cleared.
  - Outputs all 0: `wt_rd_en`, `wt_rd_addr`, `ker_load`, `act_ready`, `mul_valid`, `mul_last`, `busy`, `done`, `perf_stall`.
  - In-flight tiles are discarded.
- `start` sampled high at edge 0:
  - cycle 1: rd addr `wt_base`.
  - cycles 2/3/4: `ker_load`=001/010/100.
  - cycle 5: first `act_ready`.
- Fire in cycle t → `mul_valid` in cycle t+PE_LAT.
- Last fire in cycle t → `done` in cycle t+PE_LAT+1. IDLE at t+PE_LAT+2; `start` accepted in that cycle.
- With N tiles and no stalls, a pass lasts 4+N+PE_LAT+1 busy cycles.

## Configuration
- `PE_ARRAY_CTRL_PERF_EN` defined:
  - `perf_stall` counts STREAM cycles with `act_valid`=0.
  - Cleared on accepted `start`; saturates at all-ones; holds after `done`.
- Undefined: counter logic absent; `perf_stall` tied to 0. All other behaviour is identical.

## Structure
- `pe_ctrl_pkg` holds:
  - state enum (IDLE, LOAD, STREAM, DRAIN, DONE);
  - `PE_ROWS`=3;
  - `KER_LOAD_ROW0/1/2` one-hot constants;
  - `LOAD_CYCLES`=4.
- Sub-module `pe_valid_pipe`: PE_LAT-deep shift register carrying {valid, last}, synchronously cleared by `rst`.

## Test plan
- `wt_base`=0x3FE, `num_tiles`=2, `act_valid` held 1, PE_LAT=1:
  - rd addrs 0x3FE, 0x3FF, 0x000 (wrap);
  - `ker_load` 001/010/100 in cycles 2–4;
  - `mul_valid` cycles 6–7, `mul_last` in cycle 7;
  - `done` in cycle 8.
- `num_tiles`=0 → three loads, no `act_ready` fire, no `mul_valid`, `done` 1 cycle after DRAIN.
- `num_tiles`=4, `act_valid` toggling 1,0,1,0,… → exactly 4 `mul_valid` pulses, each PE_LAT after its fire. With PERF_EN, `perf_stall`=3.
- `start` pulsed during STREAM → ignored, tile count unchanged. Back-to-back `start` in the IDLE cycle after DONE → accepted.
- `rst` asserted mid-STREAM with PE_LAT=3 → next cycle all outputs 0, no residual `mul_valid`, `busy`=0.
- PE_LAT=3, `num_tiles`=1 → `mul_valid`=`mul_last`=1 at fire+3, `done` at fire+4.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE array kernel sequencer.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStream,
    StDrain,
    StDone
  } pe_state_e;

  localparam int unsigned PE_ROWS     = 3;
  localparam int unsigned LOAD_CYCLES = 4;

  localparam logic [PE_ROWS-1:0] KER_LOAD_ROW0 = 3'b001;
  localparam logic [PE_ROWS-1:0] KER_LOAD_ROW1 = 3'b010;
  localparam logic [PE_ROWS-1:0] KER_LOAD_ROW2 = 3'b100;

  // Row data returns one cycle after its read, so phase p latches row p-1.
  function automatic logic [PE_ROWS-1:0] ker_row_strobe(input logic [1:0] phase);
    logic [PE_ROWS-1:0] strobe;
    strobe = '0;
    case (phase)
      2'd1:    strobe = KER_LOAD_ROW0;
      2'd2:    strobe = KER_LOAD_ROW1;
      2'd3:    strobe = KER_LOAD_ROW2;
      default: strobe = '0;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/pe_valid_pipe.sv
// PE_LAT-deep {valid, last} delay line matching the PE multiply latency.
module pe_valid_pipe #(
  parameter int unsigned PE_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o
);

  logic [PE_LAT-1:0] valid_q;
  logic [PE_LAT-1:0] last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      last_q[0]  <= last_i;
      for (int i = 1; i < int'(PE_LAT); i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[PE_LAT-1];
  assign last_o  = last_q[PE_LAT-1];

endmodule

// File: rtl/pe_array_ctrl.sv
// Kernel sequencer for the 3x3 PE array: weight load, tile streaming, multiply-latency drain.
// Optional stall counter enabled by defining PE_ARRAY_CTRL_PERF_EN.
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned TILE_W = 16,
  parameter int unsigned PE_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  wt_base,
  input  logic [TILE_W-1:0]  num_tiles,
  output logic               wt_rd_en,
  output logic [ADDR_W-1:0]  wt_rd_addr,
  output logic [PE_ROWS-1:0] ker_load,
  input  logic               act_valid,
  output logic               act_ready,
  output logic               mul_valid,
  output logic               mul_last,
  output logic               busy,
  output logic               done,
  output logic [TILE_W-1:0]  perf_stall
);

  localparam int unsigned       DrainW    = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(PE_LAT - 1);
  localparam logic [1:0]        PhaseLast = 2'(LOAD_CYCLES - 1);

  pe_state_e         state_q, state_d;
  logic [1:0]        phase_q;
  logic [ADDR_W-1:0] base_q;
  logic [TILE_W-1:0] tiles_q;
  logic [DrainW-1:0] drain_q;

  logic accept;
  logic fire;
  logic last_fire;

  assign accept    = (state_q == StIdle) && start;
  assign fire      = act_valid && act_ready;
  assign last_fire = fire && (tiles_q == TILE_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StLoad;
      StLoad: begin
        if (phase_q == PhaseLast) begin
          state_d = (tiles_q == '0) ? StDrain : StStream;
        end
      end
      StStream: if (last_fire) state_d = StDrain;
      StDrain:  if (drain_q == DrainLast) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    wt_rd_en   = 1'b0;
    wt_rd_addr = '0;
    ker_load   = '0;
    act_ready  = 1'b0;
    busy       = (state_q != StIdle);
    done       = 1'b0;
    case (state_q)
      StLoad: begin
        wt_rd_en   = (phase_q != PhaseLast);
        wt_rd_addr = wt_rd_en ? base_q + ADDR_W'(phase_q) : '0;
        ker_load   = ker_row_strobe(phase_q);
      end
      StStream: act_ready = 1'b1;
      StDone:   done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      base_q  <= '0;
      tiles_q <= '0;
      drain_q <= '0;
    end else begin
      if (accept) begin
        phase_q <= '0;
        base_q  <= wt_base;
        tiles_q <= num_tiles;
      end
      if (state_q == StLoad) phase_q <= phase_q + 2'd1;
      if (fire) tiles_q <= tiles_q - TILE_W'(1);
      drain_q <= (state_q == StDrain) ? drain_q + DrainW'(1) : '0;
    end
  end

  pe_valid_pipe #(
    .PE_LAT(PE_LAT)
  ) u_valid_pipe (
    .clk    (clk),
    .rst    (rst),
    .valid_i(fire),
    .last_i (last_fire),
    .valid_o(mul_valid),
    .last_o (mul_last)
  );

`ifdef PE_ARRAY_CTRL_PERF_EN
  logic [TILE_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((state_q == StStream) && !act_valid && (stall_q != '1)) begin
      stall_q <= stall_q + TILE_W'(1);
    end
  end

  assign perf_stall = stall_q;
`else
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Randomised bench for pe_array_ctrl at PE_LAT=1 and PE_LAT=3 against a pass-timeline model.
module tb_pe_array_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, act_valid;
  logic [9:0]  wt_base;
  logic [15:0] num_tiles;

  logic [1:0]  rd_en, ready, mv, ml, busy, done;
  logic [9:0]  rd_addr [2];
  logic [2:0]  ker     [2];
  logic [15:0] stall   [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mode   = 0;

  // Per-lane pass model: t counts cycles since start acceptance (first LOAD cycle is t=1).
  int          lat [2] = '{1, 3};
  bit          m_busy  [2];
  int          m_t     [2];
  int          m_rem   [2];
  int          m_drain [2];
  int          m_stall [2];
  logic [9:0]  m_base  [2];
  bit          dv [2][4];
  bit          dl [2][4];

  always #5 clk = ~clk;

  pe_array_ctrl #(.ADDR_W(10), .TILE_W(16), .PE_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst), .start(start), .wt_base(wt_base), .num_tiles(num_tiles),
    .wt_rd_en(rd_en[0]), .wt_rd_addr(rd_addr[0]), .ker_load(ker[0]),
    .act_valid(act_valid), .act_ready(ready[0]), .mul_valid(mv[0]), .mul_last(ml[0]),
    .busy(busy[0]), .done(done[0]), .perf_stall(stall[0])
  );

  pe_array_ctrl #(.ADDR_W(10), .TILE_W(16), .PE_LAT(3)) dut_lat3 (
    .clk(clk), .rst(rst), .start(start), .wt_base(wt_base), .num_tiles(num_tiles),
    .wt_rd_en(rd_en[1]), .wt_rd_addr(rd_addr[1]), .ker_load(ker[1]),
    .act_valid(act_valid), .act_ready(ready[1]), .mul_valid(mv[1]), .mul_last(ml[1]),
    .busy(busy[1]), .done(done[1]), .perf_stall(stall[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_busy[l] = 0; m_t[l] = 0; m_rem[l] = 0; m_drain[l] = 0; m_stall[l] = 0; m_base[l] = '0;
      for (int i = 0; i < 4; i++) begin dv[l][i] = 0; dl[l][i] = 0; end
    end
  endtask

  task automatic check_lane(input int l);
    logic       e_rd, e_rdy, e_done;
    logic [9:0] e_addr;
    logic [2:0] e_ker;
    int         t;
    string      sfx;
    t = m_t[l]; e_rd = 0; e_rdy = 0; e_done = 0; e_addr = '0; e_ker = '0;
    sfx = $sformatf(" lane%0d cyc%0d", l, cyc);
    if (m_busy[l]) begin
      if (t <= 4) begin
        if (t <= 3) begin e_rd = 1; e_addr = m_base[l] + 10'(t - 1); end
        if (t >= 2) e_ker = 3'(1 << (t - 2));
      end else if (m_rem[l] > 0) begin
        e_rdy = 1;
      end else if (t == m_drain[l] + lat[l]) begin
        e_done = 1;
      end
    end
    check({"wt_rd_en", sfx}, 32'(rd_en[l]), 32'(e_rd));
    check({"wt_rd_addr", sfx}, 32'(rd_addr[l]), 32'(e_addr));
    check({"ker_load", sfx}, 32'(ker[l]), 32'(e_ker));
    check({"act_ready", sfx}, 32'(ready[l]), 32'(e_rdy));
    check({"mul_valid", sfx}, 32'(mv[l]), 32'(dv[l][0]));
    check({"mul_last", sfx}, 32'(ml[l]), 32'(dl[l][0]));
    check({"busy", sfx}, 32'(busy[l]), 32'(m_busy[l]));
    check({"done", sfx}, 32'(done[l]), 32'(e_done));
`ifdef PE_ARRAY_CTRL_PERF_EN
    check({"perf_stall", sfx}, 32'(stall[l]), 32'(m_stall[l]));
`else
    check({"perf_stall", sfx}, 32'(stall[l]), 32'd0);
`endif
  endtask

  task automatic model_step(input int l);
    bit stream, fire, last;
    int L;
    L = lat[l];
    stream = m_busy[l] && (m_t[l] >= 5) && (m_rem[l] > 0);
    fire   = stream && act_valid;
    last   = fire && (m_rem[l] == 1);
    for (int i = 0; i < L - 1; i++) begin dv[l][i] = dv[l][i+1]; dl[l][i] = dl[l][i+1]; end
    dv[l][L-1] = fire;
    dl[l][L-1] = last;
    if (m_busy[l]) begin
      if (stream) begin
        if (!act_valid && m_stall[l] < 65535) m_stall[l]++;
        if (fire) begin
          m_rem[l]--;
          if (m_rem[l] == 0) m_drain[l] = m_t[l] + 1;
        end
      end else if (m_rem[l] == 0 && m_t[l] >= 5 && m_t[l] == m_drain[l] + L) begin
        m_busy[l] = 0;
      end
      if (m_busy[l]) m_t[l]++;
    end else if (start) begin
      m_busy[l] = 1; m_t[l] = 1; m_base[l] = wt_base; m_rem[l] = int'(num_tiles);
      m_stall[l] = 0; m_drain[l] = (num_tiles == 0) ? 5 : 0;
    end
  endtask

  task automatic cycle();
    case (mode)
      0:       act_valid = 1'b1;
      1:       act_valid = (m_t[0] % 2 == 1);
      default: act_valid = ($urandom_range(0, 3) != 0);
    endcase
    @(negedge clk);
    check_lane(0);
    check_lane(1);
    if (rst) model_reset();
    else begin model_step(0); model_step(1); end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_idle(input int max);
    int k = 0;
    while ((m_busy[0] || m_busy[1]) && k < max) begin cycle(); k++; end
    check("idle_timeout", 32'(m_busy[0] | m_busy[1]), 32'd0);
    cycle();
  endtask

  task automatic pulse_start(input logic [9:0] base, input logic [15:0] n);
    wt_base = base; num_tiles = n; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; act_valid = 1'b0; wt_base = '0; num_tiles = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    cycle();

    mode = 0;
    pulse_start(10'h3FE, 16'd2);
    run_idle(60);

    pulse_start(10'h155, 16'd0);
    run_idle(60);

    mode = 1;
    pulse_start(10'h020, 16'd4);
    run_idle(60);
`ifdef PE_ARRAY_CTRL_PERF_EN
    check("perf_toggle", 32'(stall[0]), 32'd3);
`endif

    mode = 0;
    pulse_start(10'h100, 16'd6);
    repeat (5) cycle();
    wt_base = 10'h2AA; num_tiles = 16'd2; start = 1'b1;
    repeat (2) cycle();
    start = 1'b0;
    run_idle(60);

    wt_base = 10'h3FF; num_tiles = 16'd1; start = 1'b1;
    repeat (25) cycle();
    start = 1'b0;
    run_idle(60);

    pulse_start(10'h010, 16'd10);
    repeat (7) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (4) cycle();
    check("busy_after_rst", 32'(busy[1]), 32'd0);

    mode = 2;
    for (int it = 0; it < 40; it++) begin
      pulse_start(10'($urandom), 16'($urandom_range(0, 5)));
      if (it % 7 == 3) begin
        repeat ($urandom_range(1, 12)) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
      run_idle(300);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
